// File: rtl/tg_pkg.sv
// Shared types for the TCM port arbiter: arbitration phase and read-response owner.
package tg_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HOST  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_LSU  = 1'b0,
        OWN_HOST = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/tcm_port_arbiter_if.sv
// Bundle of the LSU, host-loader, halt handshake and TCM rw-port signals around the arbiter.
interface tcm_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              lsu_req;
    logic              lsu_we;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic              lsu_gnt;
    logic              lsu_rvalid;
    logic [DATA_W-1:0] lsu_rdata;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic              host_halt_req;
    logic              host_halt_ack;
    logic              cpu_stall;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // The arbiter side: takes requests and memory read data, drives grants and the TCM command.
    modport slave (
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  host_halt_req, mem_rdata,
        output lsu_gnt, lsu_rvalid, lsu_rdata,
        output host_gnt, host_rvalid, host_rdata,
        output host_halt_ack, cpu_stall,
        output mem_we, mem_addr, mem_wdata
    );

    modport master (
        output lsu_req, lsu_we, lsu_addr, lsu_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output host_halt_req, mem_rdata,
        input  lsu_gnt, lsu_rvalid, lsu_rdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  host_halt_ack, cpu_stall,
        input  mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/tcm_port_arbiter.sv
// Shares the single TCM rw-port between the core LSU and the program loader, with
// starvation protection for the host and a halt/drain handshake for exclusive host ownership.
module tcm_port_arbiter
    import tg_pkg::*;
#(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    tcm_port_arbiter_if.slave bus
);

    localparam int               CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             rd_pending_q, rd_pending_d;
    arb_owner_t       rd_owner_q, rd_owner_d;

    logic              lsu_gnt, host_gnt, starved;
    logic              lsu_rvalid, host_rvalid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign starved = (starve_cnt_q == LIMIT);

    // Outside RUN the LSU is locked out, so the host wins whenever it asks.
    always_comb begin
        lsu_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (rst_n) begin
            case (state_q)
                RUN: begin
                    if (bus.host_req && (!bus.lsu_req || starved)) host_gnt = 1'b1;
                    else                                           lsu_gnt  = bus.lsu_req;
                end
                DRAIN, HOST: host_gnt = bus.host_req;
                default: ;
            endcase
        end
    end

    assign sel_addr  = host_gnt ? bus.host_addr  : bus.lsu_addr;
    assign sel_wdata = host_gnt ? bus.host_wdata : bus.lsu_wdata;

    assign bus.lsu_gnt   = lsu_gnt;
    assign bus.host_gnt  = host_gnt;
    assign bus.mem_we    = (lsu_gnt & bus.lsu_we) | (host_gnt & bus.host_we);
    assign bus.mem_addr  = sel_addr;
    assign bus.mem_wdata = sel_wdata;

    // Responses are gated by rst_n so a read caught by reset never surfaces.
    assign lsu_rvalid      = rst_n & rd_pending_q & (rd_owner_q == OWN_LSU);
    assign host_rvalid     = rst_n & rd_pending_q & (rd_owner_q == OWN_HOST);
    assign bus.lsu_rvalid  = lsu_rvalid;
    assign bus.host_rvalid = host_rvalid;
    assign bus.lsu_rdata   = lsu_rvalid  ? bus.mem_rdata : '0;
    assign bus.host_rdata  = host_rvalid ? bus.mem_rdata : '0;

    assign bus.cpu_stall     = rst_n & (state_q != RUN);
    assign bus.host_halt_ack = rst_n & (state_q == HOST);

    always_comb begin
        rd_pending_d = (lsu_gnt & ~bus.lsu_we) | (host_gnt & ~bus.host_we);
        rd_owner_d   = rd_owner_q;
        if (host_gnt)     rd_owner_d = OWN_HOST;
        else if (lsu_gnt) rd_owner_d = OWN_LSU;

        starve_cnt_d = starve_cnt_q;
        if (host_gnt)                      starve_cnt_d = '0;
        else if (bus.host_req && !starved) starve_cnt_d = starve_cnt_q + 1'b1;

        // DRAIN leaves on the edge where the last LSU response is being delivered.
        state_d = state_q;
        case (state_q)
            RUN:   if (bus.host_halt_req) state_d = DRAIN;
            DRAIN: begin
                if (!bus.host_halt_req)  state_d = RUN;
                else if (!rd_pending_d)  state_d = HOST;
            end
            HOST: begin
                if (!bus.host_halt_req) begin
                    state_d      = RUN;
                    starve_cnt_d = '0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RUN;
            starve_cnt_q <= '0;
            rd_pending_q <= 1'b0;
            rd_owner_q   <= OWN_LSU;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

endmodule

// File: doc/tcm_port_arbiter.md
TCM_PORT_ARBITER -- requirements
Module: tcm_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, TCM byte address width.
REQ-002 SHALL have parameter DATA_W, default 32, TCM data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, host wait cycles before a forced host grant.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports lsu_req/lsu_we  in  1/1  LSU access request / write enable.
REQ-007 SHALL have ports lsu_addr/lsu_wdata  in  ADDR_W/DATA_W  LSU address / write data.
REQ-008 SHALL have ports lsu_gnt/lsu_rvalid  out  1/1  LSU accepted / read data valid.
REQ-009 SHALL have port lsu_rdata  out  DATA_W  LSU read data.
REQ-010 SHALL have ports host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata, with the same widths and meanings as the LSU set, for the program loader.
REQ-011 SHALL have ports host_halt_req  in  1  and host_halt_ack  out  1, for the exclusive-ownership request and its acknowledge.
REQ-012 SHALL have port cpu_stall  out  1  freezes the core pipeline.
REQ-013 SHALL have ports mem_we/mem_addr/mem_wdata  out  1/ADDR_W/DATA_W  TCM rw-port command.
REQ-014 SHALL have port mem_rdata  in  DATA_W  TCM read data, valid 1 cycle after the command.

Function
REQ-015 SHALL implement the states RUN, DRAIN and HOST.
REQ-016 SHALL make gnt combinational: it is asserted in the cycle the access is driven onto mem_*, and only one gnt is high per cycle.
REQ-017 SHALL hold mem_we=0 when no grant is given; mem_addr and mem_wdata are don't-care then.
REQ-018 In RUN, SHALL grant the LSU when lsu_req is high, unless starve_cnt==STARVE_LIMIT and host_req is high, in which case it SHALL grant the host.
REQ-019 In RUN, SHALL grant the host when host_req is high and lsu_req is low.
REQ-020 SHALL increment starve_cnt, saturating at STARVE_LIMIT, in each cycle with host_req=1 and host_gnt=0, and SHALL clear it on a host grant.
REQ-021 For each granted read (we=0), SHALL assert rvalid to the granted requester exactly 1 cycle later with rdata=mem_rdata; the owner is registered at grant.
REQ-022 SHALL generate no rvalid for writes.
REQ-023 SHALL hold the rdata of the non-owning requester at 0.
REQ-024 SHALL keep rd_pending set during the cycle after a granted read.
REQ-025 RUN->DRAIN when host_halt_req=1; cpu_stall SHALL be 1 from the next cycle onward.
REQ-026 In DRAIN, SHALL issue no LSU grants, and host grants SHALL follow RUN rules with lsu_req treated as 0.
REQ-027 DRAIN->HOST when rd_pending=0 and host_halt_req=1; DRAIN->RUN when host_halt_req=0.
REQ-028 In HOST, SHALL assert host_halt_ack=1 and cpu_stall=1, grant only the host, and force lsu_gnt=0.
REQ-029 HOST->RUN when host_halt_req=0; cpu_stall and host_halt_ack SHALL be 0 from the next cycle, and starve_cnt SHALL clear.
REQ-030 SHALL deliver an outstanding read response on the transition cycle that leaves DRAIN.
REQ-031 SHALL apply a simultaneous halt request and LSU request in RUN as follows: the LSU is granted that cycle and DRAIN waits for its read data.
REQ-032 SHALL never produce lsu_gnt=1 while host_halt_ack=1.

Reset
REQ-033 While rst_n=0 at a clock edge, SHALL set state=RUN, starve_cnt=0, rd_pending=0, cpu_stall=0, host_halt_ack=0, lsu_rvalid=0 and host_rvalid=0.
REQ-034 While rst_n=0, SHALL force all gnt and mem_we to 0.
REQ-035 SHALL drop any in-flight read response on a mid-operation reset, with no rvalid afterwards.

Structure
REQ-036 SHALL place arb_state_t (RUN/DRAIN/HOST) and the owner enum (OWN_LSU/OWN_HOST) in the shared package tg_pkg.
REQ-037 SHALL be a single module with no sub-modules, with state, starve_cnt, rd_pending and rd_owner as its only registers.

Verification
REQ-038 SHALL cover an LSU read of addr 0x010 with mem_rdata=0xDEADBEEF -> lsu_gnt same cycle, lsu_rvalid=1 and lsu_rdata=0xDEADBEEF next cycle, host_rvalid=0.
REQ-039 SHALL cover lsu_req held high with host_req high -> host_gnt=1 exactly on the 9th contested cycle, LSU granted otherwise, starve_cnt=0 afterwards.
REQ-040 SHALL cover host_halt_req asserted in the cycle of an LSU read grant -> DRAIN for 1 cycle, lsu_rvalid=1 in that cycle, host_halt_ack=1 one cycle later, cpu_stall=1 throughout.
REQ-041 SHALL cover a host write of 0x00000013 to 0x004 in HOST while lsu_req=1 -> mem_we=1, mem_addr=0x004, lsu_gnt=0, no rvalid.
REQ-042 SHALL cover host_halt_req dropped in HOST -> cpu_stall=0 and host_halt_ack=0 next cycle, and the LSU granted on its next request.
REQ-043 SHALL cover rst_n=0 pulsed the cycle after a read grant -> no rvalid, all outputs 0, state RUN.
